adc_capture_fifo: RTL
=====================

Name: adc_capture_fifo

Overview:
Parametrised single-clock capture buffer between the ADC sample interface and downstream readout/debug logic.
Successor to the fixed 12-bit ADC FIFO, adding:
- sample-valid qualification and integer decimation
- almost-full/almost-empty thresholds and a fill-level output
- sticky overflow/underflow flags
- a one-shot armed-capture mode alongside continuous streaming.

Parameters:
DATA_W, 12, sample width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
AFULL_TH, 12, afull_o asserted when level >= AFULL_TH
AEMPTY_TH, 2, aempty_o asserted when level <= AEMPTY_TH
DECIM, 1, keep one of every DECIM valid samples (1 = no decimation, max 256)
CAP_LEN, 16, accepted samples stored per one-shot capture (1..DEPTH)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sample_i  in  DATA_W  ADC sample
sample_vld_i  in  1  sample_i valid this cycle
mode_i  in  1  0 = continuous, 1 = one-shot
arm_i  in  1  single-cycle pulse, starts a one-shot capture
clr_i  in  1  synchronous flush
rden_i  in  1  read request
rdata_o  out  DATA_W  read data, registered
rvalid_o  out  1  rdata_o valid (one cycle)
full_o  out  1  level == DEPTH
empty_o  out  1  level == 0
afull_o  out  1  almost full
aempty_o  out  1  almost empty
level_o  out  ADDR_W+1  current occupancy, 0..DEPTH
ovf_o  out  1  sticky: a sample was dropped because the buffer was full
udf_o  out  1  sticky: read attempted while empty
busy_o  out  1  one-shot capture in progress
done_o  out  1  one-shot capture complete

Behaviour:
- Reset (rst_n low, async):
  - pointers, level_o, rdata_o, rvalid_o, ovf_o, udf_o, busy_o, done_o, decimator all 0
  - empty_o = 1, aempty_o = 1, full_o = 0, afull_o = 0
  - FSM in IDLE
- clr_i:
  - same clearing effect as reset, applied synchronously
  - highest priority; rden_i, sample_vld_i and arm_i in the same cycle are ignored
- Decimator:
  - modulo-DECIM counter advances on each sample_vld_i
  - a sample is accepted when sample_vld_i=1 and counter==0
  - counter also clears on arm_i accepted in IDLE/DONE
- Write enable:
  - continuous mode: any accepted sample
  - one-shot mode: accepted sample while state==CAPTURE
- Write when full:
  - without a read in the same cycle: sample is dropped, ovf_o set
  - with a read in the same cycle: write succeeds, level unchanged
- Reads:
  - read when rden_i=1 and not empty
  - rdata_o and rvalid_o registered: valid 1 cycle after rden_i; no first-word fall-through
  - rvalid_o=0 otherwise; rdata_o holds its last value
  - rden_i while empty: no pop, udf_o set; a same-cycle write still proceeds
- level_o: +1 on write only, -1 on read only, unchanged on both or neither
- Flags: all flags registered, derived from next-state level, so they are consistent with level_o every cycle
- Pointers: wrap modulo DEPTH; level_o reaches DEPTH exactly when full
- One-shot FSM (mode_i=1):
  - IDLE --arm_i--> CAPTURE: capture counter=0, busy_o=1, done_o=0
  - CAPTURE: counter +1 per successful write
    - dropped (overflow) samples do not count
    - arm_i ignored
  - CAPTURE --counter==CAP_LEN--> DONE: busy_o=0, done_o=1, writes stop
  - DONE --arm_i--> CAPTURE (re-arm); stored data is kept and readout continues
- Mode switching:
  - mode_i=0 forces the FSM to IDLE next cycle, busy_o=0, done_o=0
  - switching mode never flushes data
- Sticky flags: ovf_o and udf_o cleared only by rst_n or clr_i

Test Plan:
1. Continuous, DECIM=1, write 16 samples 0x000..0x00F, no reads -> full_o=1, level_o=16, afull_o rises at the 12th write; a 17th sample is dropped and ovf_o=1; reads 16 times return 0x000..0x00F, each with rvalid_o one cycle after rden_i.
2. DECIM=4, sample_vld_i held high with sample_i = cycle index 0..15 -> stored values 0,4,8,12, level_o=4.
3. Full, then simultaneous rden_i+sample_vld_i(0xABC) -> level_o stays 16, oldest word out, 0xABC becomes the newest entry, ovf_o unchanged.
4. Empty, rden_i pulse -> rvalid_o=0, udf_o=1; rden_i+write 0x123 in the same cycle -> level_o=1, a later read returns 0x123.
5. One-shot, CAP_LEN=8: arm_i, 20 valid samples -> busy_o for 8 writes, then done_o=1, level_o=8; arm_i again -> 8 more writes (level_o=16).
6. clr_i mid-capture with level_o=5, ovf_o=1 -> next cycle level_o=0, empty_o=1, ovf_o=0, FSM IDLE; async rst_n pulse mid-read clears rvalid_o immediately.

Source files
------------

// File: rtl/adc_capture_fifo.sv
// rtl/adc_capture_fifo.sv - ADC sample capture FIFO with decimation, thresholds and one-shot capture
module adc_capture_fifo #(
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int DECIM     = 1,
    parameter int CAP_LEN   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_vld_i,
    input  logic              mode_i,
    input  logic              arm_i,
    input  logic              clr_i,
    input  logic              rden_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              afull_o,
    output logic              aempty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              ovf_o,
    output logic              udf_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_L  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_L = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] CAP_LAST = (ADDR_W + 1)'(CAP_LEN - 1);
    localparam logic [7:0]      DEC_MAX  = 8'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d, cnt_q, cnt_d;
    logic [7:0]        dcnt_q, dcnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic              full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic accept, arm_ok, wr_req, rd_ok, wr_ok;

    always_comb begin
        accept = sample_vld_i && (dcnt_q == 8'd0);
        arm_ok = mode_i && arm_i && (state_q != CAPTURE);
        wr_req = accept && (!mode_i || state_q == CAPTURE);
        rd_ok  = !clr_i && rden_i && !empty_q;
        // A full buffer still takes a write when a read frees a slot in the same cycle.
        wr_ok  = !clr_i && wr_req && (!full_q || rd_ok);

        dcnt_d   = dcnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        rvalid_d = rd_ok;
        ovf_d    = ovf_q || (wr_req && !wr_ok);
        udf_d    = udf_q || (rden_i && empty_q);
        state_d  = state_q;
        cnt_d    = cnt_q;

        if (arm_ok) begin
            dcnt_d = 8'd0;
        end else if (sample_vld_i) begin
            dcnt_d = (dcnt_q == DEC_MAX) ? 8'd0 : dcnt_q + 8'd1;
        end

        if (wr_ok) wptr_d = wptr_q + 1'b1;
        if (rd_ok) begin
            rptr_d  = rptr_q + 1'b1;
            rdata_d = mem_q[rptr_q];
        end
        if (wr_ok && !rd_ok) level_d = level_q + 1'b1;
        if (rd_ok && !wr_ok) level_d = level_q - 1'b1;

        if (!mode_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm_i) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                    end
                end
                CAPTURE: begin
                    if (wr_ok) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CAP_LAST) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (clr_i) begin
            dcnt_d   = 8'd0;
            wptr_d   = '0;
            rptr_d   = '0;
            level_d  = '0;
            rdata_d  = '0;
            rvalid_d = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            state_d  = IDLE;
            cnt_d    = '0;
        end

        full_d   = (level_d == DEPTH_L);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            dcnt_q   <= 8'd0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= sample_i;
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign afull_o  = afull_q;
    assign aempty_o = aempty_q;
    assign level_o  = level_q;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;
    assign busy_o   = (state_q == CAPTURE);
    assign done_o   = (state_q == DONE);
endmodule
